branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the five-stage RV32I pipeline, sitting beside `pcReg`. In Fetch it supplies a predicted direction and target for the current PC. In Execute it takes the resolved outcome, updates its tables, and raises a one-cycle redirect when the prediction was wrong. This replaces the static not-taken fetch path (PC+4 unless `pcSrc`) and adds a direct-mapped BTB, 2-bit saturating counters, and mispredict statistics.

---
 rtl/bp_pkg.sv | 30 +++
 rtl/bp_sat_counter.sv | 25 ++
 rtl/branch_predictor.sv | 108 ++++++++++
 tb/tb_branch_predictor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Branch predictor shared types.
// Counter encoding and saturating update.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT,
    WNT,
    WT,
    ST
  } bpCnt_t;

  localparam bpCnt_t BP_ALLOC_CNT = WT;

  function automatic bpCnt_t satUpdate(
    bpCnt_t c,
    logic   taken
  );
    bpCnt_t n;
    n = c;
    unique case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One 2-bit saturating direction counter.
// Allocation forces weak-taken.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   upd,
  input  logic   alloc,
  input  logic   taken,
  output bpCnt_t cnt
);

  // Counter state: alloc overrides a normal hit update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= WNT;
    end else if (alloc) begin
      cnt <= BP_ALLOC_CNT;
    end else if (upd) begin
      cnt <= satUpdate(cnt, taken);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit BHT predictor.
// Fetch lookup, Execute update and redirect.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 64,
  parameter int IDX_W      = $clog2(ENTRIES),
  parameter int TAG_W      = ADDR_WIDTH - IDX_W - 2,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] PCf,
  output logic                  predTakenF,
  output logic [ADDR_WIDTH-1:0] predTargetF,
  input  logic                  branchE,
  input  logic [ADDR_WIDTH-1:0] PCe,
  input  logic                  takenE,
  input  logic [ADDR_WIDTH-1:0] targetE,
  input  logic                  predTakenE,
  input  logic [ADDR_WIDTH-1:0] predTargetE,
  output logic                  mispredictE,
  output logic [ADDR_WIDTH-1:0] redirectPCE,
  output logic [CNT_W-1:0]      branchCount,
  output logic [CNT_W-1:0]      mispredictCount
);

  logic                  valid  [ENTRIES];
  logic [TAG_W-1:0]      tagArr [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgtArr [ENTRIES];
  bpCnt_t                cnt    [ENTRIES];

  logic [IDX_W-1:0] idxF;
  logic [IDX_W-1:0] idxE;
  logic [TAG_W-1:0] tagF;
  logic [TAG_W-1:0] tagE;
  logic             hitE;
  logic             allocE;

  assign idxF = PCf[IDX_W+1:2];
  assign tagF = PCf[ADDR_WIDTH-1:IDX_W+2];
  assign idxE = PCe[IDX_W+1:2];
  assign tagE = PCe[ADDR_WIDTH-1:IDX_W+2];

  assign hitE   = valid[idxE] && (tagArr[idxE] == tagE);
  assign allocE = branchE && !hitE && takenE;

  // Fetch lookup from registered state only; no bypass
  always_comb begin
    predTakenF  = valid[idxF]
                && (tagArr[idxF] == tagF)
                && cnt[idxF][1];
    predTargetF = predTakenF ? tgtArr[idxF]
                             : PCf + ADDR_WIDTH'(4);
  end

  // Execute resolution: gated redirect request
  always_comb begin
    mispredictE = branchE
      && ((takenE != predTakenE)
       || (takenE && (targetE != predTargetE)));
    redirectPCE = takenE ? targetE
                         : PCe + ADDR_WIDTH'(4);
  end

  // BTB valid/tag/target tables
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tagArr[i] <= '0;
        tgtArr[i] <= '0;
      end
    end else if (branchE && takenE) begin
      if (!hitE) begin
        valid[idxE]  <= 1'b1;
        tagArr[idxE] <= tagE;
      end
      tgtArr[idxE] <= targetE;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    bp_sat_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .upd   (branchE && hitE && (idxE == IDX_W'(g))),
      .alloc (allocE && (idxE == IDX_W'(g))),
      .taken (takenE),
      .cnt   (cnt[g])
    );
  end

  // Statistics, free-running and wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branchCount     <= '0;
      mispredictCount <= '0;
    end else begin
      if (branchE)
        branchCount <= branchCount + CNT_W'(1);
      if (mispredictE)
        mispredictCount <= mispredictCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor.
// Directed vectors, monitor checks on negedge.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] PCf;
  logic        predTakenF;
  logic [31:0] predTargetF;
  logic        branchE;
  logic [31:0] PCe;
  logic        takenE;
  logic [31:0] targetE;
  logic        predTakenE;
  logic [31:0] predTargetE;
  logic        mispredictE;
  logic [31:0] redirectPCE;
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;

  typedef struct packed {
    logic        ptf;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t  sb [$];
  string sb_name [$];
  int    applied;
  int    miscompares;

  branch_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .PCf             (PCf),
    .predTakenF      (predTakenF),
    .predTargetF     (predTargetF),
    .branchE         (branchE),
    .PCe             (PCe),
    .takenE          (takenE),
    .targetE         (targetE),
    .predTakenE      (predTakenE),
    .predTargetE     (predTargetE),
    .mispredictE     (mispredictE),
    .redirectPCE     (redirectPCE),
    .branchCount     (branchCount),
    .mispredictCount (mispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation
  always @(negedge clk) begin
    exp_t  e;
    string n;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n = sb_name.pop_front();
      applied++;
      if (predTakenF !== e.ptf
          || predTargetF !== e.ptg
          || mispredictE !== e.mp
          || redirectPCE !== e.rpc
          || branchCount !== e.bc
          || mispredictCount !== e.mc) begin
        miscompares++;
        $display("FAIL %s got pt=%0b tg=%h mp=%0b rpc=%h bc=%0d mc=%0d exp pt=%0b tg=%h mp=%0b rpc=%h bc=%0d mc=%0d",
          n, predTakenF, predTargetF, mispredictE,
          redirectPCE, branchCount, mispredictCount,
          e.ptf, e.ptg, e.mp, e.rpc, e.bc, e.mc);
      end
    end
  end

  task automatic vec(
    input string       name,
    input logic        r,
    input logic [31:0] pcf,
    input logic        br,
    input logic [31:0] pce,
    input logic        tk,
    input logic [31:0] tgt,
    input logic        pte,
    input logic [31:0] ptge,
    input logic        xptf,
    input logic [31:0] xptg,
    input logic        xmp,
    input logic [31:0] xrpc,
    input logic [31:0] xbc,
    input logic [31:0] xmc
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    PCf         = pcf;
    branchE     = br;
    PCe         = pce;
    takenE      = tk;
    targetE     = tgt;
    predTakenE  = pte;
    predTargetE = ptge;
    e = '{xptf, xptg, xmp, xrpc, xbc, xmc};
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    rst         = 1'b0;
    PCf         = 32'h100;
    branchE     = 1'b0;
    PCe         = 32'h0;
    takenE      = 1'b0;
    targetE     = 32'h0;
    predTakenE  = 1'b0;
    predTargetE = 32'h0;

    //  name  rst pcf br pce tk tgt pte ptge | ptf ptg mp rpc bc mc
    vec("reset", 0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,
        0, 32'h104, 0, 32'h4, 0, 0);
    vec("alloc", 1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104,
        0, 32'h104, 1, 32'h80, 0, 0);
    vec("predict", 1, 32'h100, 0, 32'h100, 0, 32'h0, 0, 32'h0,
        1, 32'h80, 0, 32'h104, 1, 1);
    vec("hyst_nt", 1, 32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h80,
        1, 32'h80, 1, 32'h104, 1, 1);
    vec("hyst_pred_nt", 1, 32'h100, 0, 32'h100, 0, 32'h0, 0, 32'h0,
        0, 32'h104, 0, 32'h104, 2, 2);
    vec("hyst_t1", 1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104,
        0, 32'h104, 1, 32'h80, 2, 2);
    vec("hyst_t2", 1, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80,
        1, 32'h80, 0, 32'h80, 3, 3);
    vec("hyst_nt_st", 1, 32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h80,
        1, 32'h80, 1, 32'h104, 4, 3);
    vec("hyst_still_t", 1, 32'h100, 0, 32'h100, 0, 32'h0, 0, 32'h0,
        1, 32'h80, 0, 32'h104, 5, 4);
    vec("tgt_mismatch", 1, 32'h100, 1, 32'h100, 1, 32'h90, 1, 32'h80,
        1, 32'h80, 1, 32'h90, 5, 4);
    vec("tgt_updated", 1, 32'h100, 0, 32'h100, 0, 32'h0, 0, 32'h0,
        1, 32'h90, 0, 32'h104, 6, 5);
    vec("alias_alloc", 1, 32'h200, 1, 32'h200, 1, 32'h40, 0, 32'h204,
        0, 32'h204, 1, 32'h40, 6, 5);
    vec("alias_old_miss", 1, 32'h100, 0, 32'h200, 0, 32'h0, 0, 32'h0,
        0, 32'h104, 0, 32'h204, 7, 6);
    vec("alias_new_hit", 1, 32'h200, 0, 32'h200, 0, 32'h0, 0, 32'h0,
        1, 32'h40, 0, 32'h204, 7, 6);
    vec("nt_miss", 1, 32'h300, 1, 32'h300, 0, 32'h0, 0, 32'h304,
        0, 32'h304, 0, 32'h304, 7, 6);
    vec("nt_no_alloc", 1, 32'h300, 0, 32'h300, 0, 32'h0, 0, 32'h0,
        0, 32'h304, 0, 32'h304, 8, 6);
    vec("branch_gate", 1, 32'h200, 0, 32'h400, 1, 32'h500, 0, 32'h0,
        1, 32'h40, 0, 32'h500, 8, 6);
    vec("gate_no_change", 1, 32'h200, 0, 32'h400, 0, 32'h0, 0, 32'h0,
        1, 32'h40, 0, 32'h404, 8, 6);
    vec("pc_wrap", 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h0, 0,
        32'h0, 0, 32'h0, 0, 32'h0, 8, 6);
    vec("async_rst", 0, 32'h200, 0, 32'h0, 0, 32'h0, 0, 32'h0,
        0, 32'h204, 0, 32'h4, 0, 0);
    vec("rst_mid_upd", 0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104,
        0, 32'h104, 1, 32'h80, 0, 0);
    vec("rst_discard", 1, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0,
        0, 32'h104, 0, 32'h4, 0, 0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain left=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
